axi_wr_arbiter: RTL and testbench



---
 rtl/axi_wr_arbiter_pkg.sv | 18 +
 rtl/rr_arbiter_pick.sv | 30 +++
 rtl/axi_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_axi_wr_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_arbiter_pkg.sv
// axi_wr_arbiter_pkg: helper status and arbiter state encodings shared by the write-side arbiter
package axi_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_OK    = 2'd2,
        ST_ERR   = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_arbiter_pick: combinational round-robin pick, first set request above last_grant (wrapping)
module rr_arbiter_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      index
);

    logic          found;
    logic [IW-1:0] c;

    // scan from last_grant+1 upward modulo NUM_REQ, keep the first hit
    always_comb begin
        found = 1'b0;
        index = '0;
        c     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[c]) begin
                found = 1'b1;
                index = c;
            end
        end
        grant = found ? NUM_REQ'(1) << index : '0;
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin sharing of one axi_wr helper among NUM_REQ burst requesters
module axi_wr_arbiter
    import axi_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 8,
    parameter int ID_BASE        = 0,
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_WIDTH      = 32,
    parameter int MAX_BURST_LEN  = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]            req_addr,
    input  logic [NUM_REQ*MAX_BURST_LEN*BUS_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*4-1:0]                     req_burst_len,
    input  logic [NUM_REQ*BUS_WIDTH/8-1:0]           req_strb,
    output logic [NUM_REQ-1:0]                       req_done,
    output logic [NUM_REQ-1:0]                       req_err,
    output logic [NUM_REQ-1:0]                       grant,
    output logic                                     busy,
    output logic                                     timeout,
    output logic                                     wr_enable,
    output logic [ID_WIDTH-1:0]                      wr_id,
    output logic [ADDR_WIDTH-1:0]                    wr_addr,
    output logic [MAX_BURST_LEN*BUS_WIDTH-1:0]       wr_data,
    output logic [3:0]                               wr_burst_len,
    output logic [BUS_WIDTH/8-1:0]                   wr_strb,
    input  logic [1:0]                               wr_status
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int DW = MAX_BURST_LEN * BUS_WIDTH;
    localparam int SW = BUS_WIDTH / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t            state;
    status_t           st;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     gidx;
    logic [IW-1:0]     pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic [TW-1:0]     wdog;

    assign st = status_t'(wr_status);

    rr_arbiter_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_oh),
        .index      (pick_idx)
    );

    // grant, descriptor capture, helper handshake, watchdog and done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= IW'(NUM_REQ - 1);
            gidx         <= '0;
            grant        <= '0;
            busy         <= 1'b0;
            timeout      <= 1'b0;
            wr_enable    <= 1'b0;
            wr_id        <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_burst_len <= '0;
            wr_strb      <= '0;
            req_done     <= '0;
            req_err      <= '0;
            wdog         <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid && st == ST_READY) begin
                    gidx         <= pick_idx;
                    grant        <= pick_oh;
                    busy         <= 1'b1;
                    wr_enable    <= 1'b1;
                    wr_id        <= ID_WIDTH'(ID_BASE) + ID_WIDTH'(pick_idx);
                    wr_addr      <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wr_data      <= req_data[pick_idx*DW +: DW];
                    wr_burst_len <= req_burst_len[pick_idx*4 +: 4];
                    wr_strb      <= req_strb[pick_idx*SW +: SW];
                    wdog         <= '0;
                    state        <= ISSUE;
                end
                ISSUE, WAIT: if (st == ST_OK || st == ST_ERR) begin
                    wr_enable <= 1'b0;
                    req_done  <= grant;
                    req_err   <= st == ST_ERR ? grant : '0;
                    state     <= RELEASE;
                end else if (wdog == TW'(TIMEOUT_CYCLES - 1)) begin
                    wr_enable <= 1'b0;
                    req_done  <= grant;
                    req_err   <= grant;
                    timeout   <= 1'b1;
                    state     <= RELEASE;
                end else begin
                    wdog <= wdog + 1'b1;
                    if (state == ISSUE && st == ST_WAIT) begin
                        wr_enable <= 1'b0;
                        state     <= WAIT;
                    end
                end
                RELEASE: begin
                    req_done   <= '0;
                    req_err    <= '0;
                    grant      <= '0;
                    busy       <= 1'b0;
                    last_grant <= gidx;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: randomized requesters and helper model checked against a round-robin reference
module tb_axi_wr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 8;
    localparam int IDB = 16;
    localparam int AW  = 32;
    localparam int BW  = 32;
    localparam int MBL = 2;
    localparam int TO  = 64;
    localparam int DW  = MBL * BW;
    localparam int SW  = BW / 8;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N*AW-1:0]      req_addr;
    logic [N*DW-1:0]      req_data;
    logic [N*4-1:0]       req_burst_len;
    logic [N*SW-1:0]      req_strb;
    logic [N-1:0]         req_done, req_err, grant;
    logic                 busy, timeout, wr_enable;
    logic [IDW-1:0]       wr_id;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [3:0]           wr_burst_len;
    logic [SW-1:0]        wr_strb;
    logic [1:0]           wr_status = 2'd0;

    logic [AW-1:0]        d_addr [N];
    logic [DW-1:0]        d_data [N];
    logic [3:0]           d_len  [N];
    logic [SW-1:0]        d_strb [N];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last  = N - 1;
    logic exp_to = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_addr[i*AW +: AW]     = d_addr[i];
        assign req_data[i*DW +: DW]     = d_data[i];
        assign req_burst_len[i*4 +: 4]  = d_len[i];
        assign req_strb[i*SW +: SW]     = d_strb[i];
    end

    axi_wr_arbiter #(
        .NUM_REQ(N), .ID_WIDTH(IDW), .ID_BASE(IDB), .ADDR_WIDTH(AW),
        .BUS_WIDTH(BW), .MAX_BURST_LEN(MBL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_burst_len(req_burst_len), .req_strb(req_strb),
        .req_done(req_done), .req_err(req_err), .grant(grant), .busy(busy),
        .timeout(timeout), .wr_enable(wr_enable), .wr_id(wr_id), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_burst_len(wr_burst_len), .wr_strb(wr_strb),
        .wr_status(wr_status)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
        cyc++;
    endtask

    task automatic new_desc(input int i);
        d_addr[i] = $urandom;
        for (int w = 0; w < MBL; w++) d_data[i][w*BW +: BW] = $urandom;
        d_len[i]  = 4'($urandom_range(0, 15));
        d_strb[i] = SW'($urandom);
    endtask

    function automatic int rr_next(input logic [N-1:0] v, input int l);
        for (int k = 1; k <= N; k++)
            if (v[(l + k) % N]) return (l + k) % N;
        return -1;
    endfunction

    // mode: 0 ok, 1 slave error, 2 fast ok, 3 fast error, 4 helper stuck (watchdog)
    task automatic serve(input int mode);
        int g, t0;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [3:0]    el;
        logic [SW-1:0] es;
        logic          err;
        g = rr_next(req_valid, last);
        if (g < 0) begin
            req_valid[0] = 1'b1;
            g = 0;
        end
        ea = d_addr[g]; ed = d_data[g]; el = d_len[g]; es = d_strb[g];
        err = (mode == 1 || mode == 3 || mode == 4);
        tick;
        t0 = cyc;
        check("grant", grant, N'(1) << g);
        check("busy", busy, 1);
        check("wr_enable_on", wr_enable, 1);
        check("wr_id", wr_id, IDW'(IDB + g));
        check("wr_addr", wr_addr, ea);
        check("wr_data", wr_data, ed);
        check("wr_burst_len", wr_burst_len, el);
        check("wr_strb", wr_strb, es);
        repeat ($urandom_range(0, 2)) begin
            tick;
            check("wr_enable_hold", wr_enable, 1);
        end
        new_desc(g);
        if ($urandom_range(0, 3) == 0) req_valid[g] = 1'b0;
        if (mode <= 1) begin
            wr_status = 2'd1;
            tick;
            check("wr_enable_drop", wr_enable, 0);
            repeat ($urandom_range(0, 3)) tick;
            wr_status = mode == 1 ? 2'd3 : 2'd2;
            tick;
            wr_status = 2'd0;
        end else if (mode <= 3) begin
            wr_status = mode == 3 ? 2'd3 : 2'd2;
            tick;
            wr_status = 2'd0;
        end else begin
            wr_status = 2'd1;
            while (req_done == '0 && cyc - t0 < TO + 8) tick;
            wr_status = 2'd0;
            check("timeout_latency", cyc - t0, TO);
            exp_to = 1'b1;
        end
        check("req_done", req_done, N'(1) << g);
        check("req_err", req_err, err ? N'(1) << g : '0);
        check("grant_held", grant, N'(1) << g);
        check("wr_enable_off", wr_enable, 0);
        check("wr_addr_stable", wr_addr, ea);
        check("timeout_flag", timeout, exp_to);
        req_valid[g] = 1'b0;
        last = g;
        tick;
        check("req_done_clear", req_done, 0);
        check("grant_clear", grant, 0);
        check("busy_clear", busy, 0);
    endtask

    task automatic raise(input logic [N-1:0] nv);
        for (int i = 0; i < N; i++)
            if (nv[i] && !req_valid[i]) begin
                new_desc(i);
                req_valid[i] = 1'b1;
            end
    endtask

    initial begin
        for (int i = 0; i < N; i++) new_desc(i);
        tick;
        tick;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_enable", wr_enable, 0);
        check("rst_done", req_done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_addr", wr_addr, 0);
        reset = 1'b0;

        d_addr[0] = 32'h1000;
        d_len[0]  = 4'd3;
        req_valid = 4'b0001;
        serve(0);

        for (int k = 0; k < 6; k++) begin
            raise('1);
            serve(rr_next(req_valid, last) == 2 ? 1 : 0);
        end

        raise(4'b0101);
        serve(4);
        raise(4'b1000);
        serve(0);

        for (int k = 0; k < 40; k++) begin
            int m;
            raise(N'($urandom));
            if (req_valid == '0) begin
                repeat (2) begin
                    tick;
                    check("idle_grant", grant, 0);
                end
                raise(N'(1) << $urandom_range(0, N - 1));
            end
            m = $urandom_range(0, 9);
            serve(m == 9 ? 4 : m % 4);
        end

        raise(4'b0110);
        tick;
        check("pre_reset_grant", grant, N'(1) << rr_next(req_valid, last));
        wr_status = 2'd1;
        tick;
        wr_status = 2'd0;
        reset = 1'b1;
        tick;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_enable", wr_enable, 0);
        check("mid_rst_done", req_done, 0);
        check("mid_rst_err", req_err, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_addr", wr_addr, 0);
        reset  = 1'b0;
        last   = N - 1;
        exp_to = 1'b0;
        raise('1);
        serve(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
